// File: rtl/imem_arb_pkg.sv
// rtl/imem_arb_pkg.sv - shared types and default sizing for the instruction memory arbiter
package imem_arb_pkg;

  typedef enum logic {ARB, LOCK} arb_state_e;
  typedef enum logic {CORE, DBG} requester_e;

  localparam int unsigned IMEM_ADDR_SIZE = 4096;
  localparam int unsigned IMEM_MAX_STALL = 8;

endpackage

// File: rtl/imem_addr_check.sv
// rtl/imem_addr_check.sv - flags byte addresses that are out of range or not word aligned
module imem_addr_check
  import imem_arb_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = IMEM_ADDR_SIZE
) (
  input  logic [31:0] addr,
  output logic        err
);

  // No wrap: anything at or above ADDR_SIZE is rejected outright.
  assign err = (addr >= ADDR_SIZE) || (addr[1:0] != 2'b00);

endmodule

// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - core/debug arbiter for the instruction memory read port
// Defining IMEM_ARB_STATS_EN adds saturating grant and conflict counters.
module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int unsigned ADDR_SIZE = IMEM_ADDR_SIZE,
  parameter int unsigned MAX_STALL = IMEM_MAX_STALL
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic [31:0] core_addr_i,
  output logic        core_gnt_o,
  output logic        core_rvalid_o,
  output logic [31:0] core_rdata_o,
  output logic        core_err_o,
  input  logic        dbg_req_i,
  input  logic [31:0] dbg_addr_i,
  input  logic        dbg_lock_i,
  output logic        dbg_gnt_o,
  output logic        dbg_rvalid_o,
  output logic [31:0] dbg_rdata_o,
  output logic        dbg_err_o,
  output logic [31:0] mem_addr_o,
  input  logic [31:0] mem_rdata_i
`ifdef IMEM_ARB_STATS_EN
  ,
  output logic [31:0] stat_core_gnt_o,
  output logic [31:0] stat_dbg_gnt_o,
  output logic [31:0] stat_conflict_o
`endif
);

  arb_state_e state_q, state_d;
  requester_e last_grant_q;
  logic [7:0] stall_cnt_q;
  logic       both_req, guard, lock_take;
  logic       core_err, dbg_err;

  imem_addr_check #(.ADDR_SIZE(ADDR_SIZE)) u_core_check (.addr(core_addr_i), .err(core_err));
  imem_addr_check #(.ADDR_SIZE(ADDR_SIZE)) u_dbg_check  (.addr(dbg_addr_i),  .err(dbg_err));

  assign both_req  = core_req_i & dbg_req_i;
  assign guard     = (state_q == LOCK) && (stall_cnt_q == 8'(MAX_STALL));
  assign lock_take = (state_q == ARB) && dbg_lock_i && dbg_req_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ARB;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB:     if (lock_take) state_d = LOCK;
      LOCK:    if (!dbg_lock_i) state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  always_comb begin
    core_gnt_o = 1'b0;
    dbg_gnt_o  = 1'b0;
    if (state_q == LOCK) begin
      // Grants here ignore dbg_lock_i so a release never cancels a guard grant.
      if (guard) core_gnt_o = core_req_i;
      else       dbg_gnt_o  = dbg_req_i;
    end else if (lock_take) begin
      dbg_gnt_o = 1'b1;
    end else if (both_req) begin
      if (last_grant_q == DBG) core_gnt_o = 1'b1;
      else                     dbg_gnt_o  = 1'b1;
    end else begin
      core_gnt_o = core_req_i;
      dbg_gnt_o  = dbg_req_i;
    end
  end

  assign mem_addr_o = dbg_gnt_o ? dbg_addr_i : core_addr_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      core_rvalid_o <= 1'b0;
      core_rdata_o  <= '0;
      core_err_o    <= 1'b0;
      dbg_rvalid_o  <= 1'b0;
      dbg_rdata_o   <= '0;
      dbg_err_o     <= 1'b0;
      last_grant_q  <= DBG;
      stall_cnt_q   <= '0;
    end else begin
      core_rvalid_o <= core_gnt_o;
      dbg_rvalid_o  <= dbg_gnt_o;
      if (core_gnt_o) begin
        core_err_o   <= core_err;
        core_rdata_o <= core_err ? 32'd0 : mem_rdata_i;
      end
      if (dbg_gnt_o) begin
        dbg_err_o   <= dbg_err;
        dbg_rdata_o <= dbg_err ? 32'd0 : mem_rdata_i;
      end
      if (core_gnt_o)     last_grant_q <= CORE;
      else if (dbg_gnt_o) last_grant_q <= DBG;
      // The lock-taking cycle already counts as a denial of a waiting core.
      if ((state_q == LOCK && !dbg_lock_i) || guard)
        stall_cnt_q <= '0;
      else if ((state_q == LOCK || lock_take) && core_req_i && !core_gnt_o)
        stall_cnt_q <= stall_cnt_q + 8'd1;
    end
  end

`ifdef IMEM_ARB_STATS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_core_gnt_o <= '0;
      stat_dbg_gnt_o  <= '0;
      stat_conflict_o <= '0;
    end else begin
      if (core_gnt_o && stat_core_gnt_o != 32'hFFFF_FFFF) stat_core_gnt_o <= stat_core_gnt_o + 32'd1;
      if (dbg_gnt_o && stat_dbg_gnt_o != 32'hFFFF_FFFF)   stat_dbg_gnt_o  <= stat_dbg_gnt_o + 32'd1;
      if (both_req && stat_conflict_o != 32'hFFFF_FFFF)   stat_conflict_o <= stat_conflict_o + 32'd1;
    end
  end
`endif

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
Two-requester arbiter sharing the single combinational read port of the instruction memory between the core fetch stage and a debug/boot reader.
- Grants at most one request per cycle, combinationally.
- Registers the read data into a per-requester response with 1-cycle latency.
- Flags out-of-range or misaligned addresses.
- Supports a debug lock mode, bounded by a starvation guard that forces periodic core grants.

Parameters:
ADDR_SIZE, 4096, instruction memory size in bytes; valid byte addresses are 0..ADDR_SIZE-1.
MAX_STALL, 8, maximum consecutive cycles a requesting core is denied while debug holds the lock; range 1..255.

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous active-high reset
core_req_i  input  1  core fetch request
core_addr_i  input  32  core byte address
core_gnt_o  output  1  core request accepted this cycle (combinational)
core_rvalid_o  output  1  core response valid (1-cycle pulse)
core_rdata_o  output  32  core response data
core_err_o  output  1  core response error, qualified by core_rvalid_o
dbg_req_i  input  1  debug read request
dbg_addr_i  input  32  debug byte address
dbg_lock_i  input  1  debug requests exclusive ownership of the port
dbg_gnt_o  output  1  debug request accepted this cycle (combinational)
dbg_rvalid_o  output  1  debug response valid (1-cycle pulse)
dbg_rdata_o  output  32  debug response data
dbg_err_o  output  1  debug response error, qualified by dbg_rvalid_o
mem_addr_o  output  32  address driven to the instruction memory
mem_rdata_i  input  32  instruction memory combinational read data

Behaviour:
- One clock clk_i. rst_i is synchronous and active-high.
- Reset values:
  - all rvalid, err and rdata outputs = 0
  - last_grant = DBG, so the core wins the first conflict
  - state = ARB
  - stall_cnt = 0
- Grant outputs are combinational. A requester holds req and addr stable until it sees gnt; a request without gnt is simply retried next cycle.
- mem_addr_o selection:
  - equals the granted requester's address
  - with no grant, equals core_addr_i
- On a grant in cycle N, the response registers are loaded at the edge ending cycle N, so rvalid is high for exactly cycle N+1.
  - rdata = mem_rdata_i, or 0 on error.
  - err = (addr >= ADDR_SIZE) or (addr[1:0] != 0).
  - The non-granted port's rvalid is 0 in cycle N+1.
  - Back-to-back grants give back-to-back rvalid pulses.
- State ARB:
  - only one request: grant it
  - both request: grant the port that is not last_grant, then update last_grant
  - dbg_lock_i=1 and dbg_req_i=1: grant debug and go to LOCK
- State LOCK:
  - debug is granted whenever dbg_req_i=1; the core is denied
  - stall_cnt increments on each cycle with core_req_i=1 and no core grant; it holds otherwise
  - when stall_cnt reaches MAX_STALL: the next cycle grants the core unconditionally (guard grant), debug is denied that cycle, stall_cnt clears, and the state stays LOCK
  - dbg_lock_i=0 returns the state to ARB on the next edge and clears stall_cnt
- Simultaneous events:
  - dbg_lock_i falling in the same cycle as a guard grant: the guard grant still occurs
  - the core's rvalid pulse is never suppressed by state changes
- Reset mid-operation: any pending rvalid is dropped (0 the cycle after reset), state = ARB, and the grant pointer is reset.
- Address wrap: no wrap; addresses 0x1000..0xFFFFFFFF always report err with rdata 0.

Optional Feature:
IMEM_ARB_STATS_EN.
- Defined:
  - adds output ports stat_core_gnt_o[31:0], stat_dbg_gnt_o[31:0] and stat_conflict_o[31:0]
  - these count grants per port and cycles where both ports requested
  - the counters saturate at 0xFFFFFFFF and clear on rst_i
- Undefined: the ports and counters are absent, and functional behaviour is identical.

Decomposition:
- Package imem_arb_pkg holds:
  - state enum {ARB, LOCK}
  - requester enum {CORE, DBG}
  - default constants IMEM_ADDR_SIZE=4096 and IMEM_MAX_STALL=8
- Sub-module imem_addr_check, instantiated twice (one per port): combinational check of a 32-bit addr against ADDR_SIZE and alignment, producing err.

Test Plan:
- Reset, then core_req=1 at addr 0x0 only -> core_gnt=1 the same cycle; next cycle core_rvalid=1, core_rdata=mem[0], core_err=0.
- Both request (core 0x10, dbg 0x20) for 4 cycles -> grants alternate core,dbg,core,dbg; rvalid pulses alternate with mem[4], mem[8].
- dbg_req=1, dbg_addr=0x1000 -> dbg_rvalid=1, dbg_err=1, dbg_rdata=0x00000000; core_addr=0x6 -> core_err=1, core_rdata=0.
- dbg_lock=1 with dbg_req=1 continuously, core_req=1, MAX_STALL=8 -> core denied 8 cycles, granted on the 9th, debug denied that cycle; the pattern repeats.
- Lock released mid-stall (stall_cnt=5) -> ARB the next cycle, stall_cnt=0, and round-robin resumes with the core winning.
- rst_i asserted in the cycle after a grant -> rvalid=0 on both ports; the first post-reset conflict is won by the core.
